// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-entry skid buffer for stalls,
// branch/jump redirect and registered IF/ID outputs.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    if_stage_if.master         imem,
    output logic [31:0]        next_pc_out,
    output logic [31:0]        instruccion_out,
    output logic               valid_out
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    logic [0:0]  state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] buf_npc_r, buf_npc_s;
    logic [31:0] buf_ins_r, buf_ins_s;
    logic [31:0] npc_r, npc_s;
    logic [31:0] ins_r, ins_s;
    logic        valid_r, valid_s;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_aligned_s;
    logic [31:0] pc_inc_s;

    assign pc_aligned_s = {pc_r[31:2], 2'b00};
    assign pc_inc_s     = pc_aligned_s + 32'd4;
    assign redirect_s   = branch_taken | jump;
    assign target_s     = branch_taken ? {branch_target[31:2], 2'b00} : {jump_target[31:2], 2'b00};

    // The request drops combinationally while reset is asserted.
    assign imem.imem_req  = rst_n & (state_r == ST_FETCH);
    assign imem.imem_addr = pc_aligned_s;

    assign next_pc_out     = npc_r;
    assign instruccion_out = ins_r;
    assign valid_out       = valid_r;

    // Next-state selection; redirect wins over stall and discards any captured word.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        buf_npc_s = buf_npc_r;
        buf_ins_s = buf_ins_r;
        npc_s     = npc_r;
        ins_s     = ins_r;
        valid_s   = valid_r;
        if (redirect_s) begin
            pc_s      = target_s;
            valid_s   = 1'b0;
            buf_npc_s = 32'h0000_0000;
            buf_ins_s = 32'h0000_0000;
            state_s   = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        if (stall) begin
                            buf_npc_s = pc_inc_s;
                            buf_ins_s = imem.imem_rdata;
                            state_s   = ST_HELD;
                        end else begin
                            npc_s   = pc_inc_s;
                            ins_s   = imem.imem_rdata;
                            valid_s = 1'b1;
                            pc_s    = pc_inc_s;
                        end
                    end else if (!stall) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                ST_HELD: begin
                    if (!stall) begin
                        npc_s   = buf_npc_r;
                        ins_s   = buf_ins_r;
                        valid_s = 1'b1;
                        pc_s    = pc_inc_s;
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_HELD;
                    end
                end
                default: begin
                    valid_s = 1'b0;
                    state_s = ST_FETCH;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            pc_r      <= RESET_PC;
            buf_npc_r <= 32'h0000_0000;
            buf_ins_r <= 32'h0000_0000;
            npc_r     <= 32'h0000_0000;
            ins_r     <= 32'h0000_0000;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            buf_npc_r <= buf_npc_s;
            buf_ins_r <= buf_ins_s;
            npc_r     <= npc_s;
            ins_r     <= ins_s;
            valid_r   <= valid_s;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, ready;
    logic [31:0] branch_target, jump_target, salt;
    logic [31:0] next_pc_out, instruccion_out;
    logic        valid_out;
    logic [31:0] next_pc_out2, instruccion_out2;
    logic        valid_out2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage_if bus ();
    if_stage_if bus2 ();

    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = bus.imem_addr ^ salt;
    assign bus2.imem_ready = 1'b1;
    assign bus2.imem_rdata = bus2.imem_addr ^ 32'hA5A5_0000;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem(bus.master),
        .next_pc_out(next_pc_out), .instruccion_out(instruccion_out), .valid_out(valid_out)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0000_0000),
        .jump(1'b0), .jump_target(32'h0000_0000), .imem(bus2.master),
        .next_pc_out(next_pc_out2), .instruccion_out(instruccion_out2), .valid_out(valid_out2)
    );

    // Behavioural model: "held" simply means a word is sitting in the buffer queue.
    logic [31:0] m_pc, m_npc, m_ins;
    logic        m_val;
    logic [63:0] m_buf[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [31:0] addr;
        logic [31:0] word;
        logic [63:0] e;
        addr = m_pc & 32'hFFFF_FFFC;
        word = addr ^ salt;
        if (!rst_n) begin
            m_pc = 32'h0000_0000; m_npc = 32'h0; m_ins = 32'h0; m_val = 1'b0;
            m_buf.delete();
        end else if (branch_taken || jump) begin
            m_pc = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
            m_val = 1'b0;
            m_buf.delete();
        end else if (m_buf.size() != 0) begin
            if (!stall) begin
                e = m_buf.pop_front();
                m_npc = e[63:32]; m_ins = e[31:0]; m_val = 1'b1;
                m_pc = addr + 32'd4;
            end
        end else if (ready) begin
            if (stall) m_buf.push_back({addr + 32'd4, word});
            else begin
                m_npc = addr + 32'd4; m_ins = word; m_val = 1'b1;
                m_pc = addr + 32'd4;
            end
        end else if (!stall) begin
            m_val = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, (rst_n === 1'b1) && (m_buf.size() == 0)});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("next_pc_out", next_pc_out, m_npc);
        chk("instruccion_out", instruccion_out, m_ins);
        chk("valid_out", {31'd0, valid_out}, {31'd0, m_val});
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; ready = 1'b1;
        branch_target = 32'h0; jump_target = 32'h0; salt = 32'hA5A5_0000;
        m_pc = 32'h0; m_npc = 32'h0; m_ins = 32'h0; m_val = 1'b0;
        step();
        step();

        // Reset release and sequential fetch
        rst_n = 1'b1;
        #1;
        compare_all();
        step();
        chk("seq_npc0", next_pc_out, 32'h0000_0004);
        chk("seq_ins0", instruccion_out, 32'hA5A5_0000);
        step();
        chk("seq_npc1", next_pc_out, 32'h0000_0008);
        chk("seq_addr1", bus.imem_addr, 32'h0000_0008);
        step();
        step();
        chk("pc_at_10", bus.imem_addr, 32'h0000_0010);

        // Stall with a ready word at 0x10
        stall = 1'b1;
        step();
        chk("held_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        step();
        stall = 1'b0;
        step();
        chk("unstall_npc", next_pc_out, 32'h0000_0014);
        chk("unstall_ins", instruccion_out, 32'h0000_0010 ^ salt);
        chk("unstall_addr", bus.imem_addr, 32'h0000_0014);
        step();

        // Branch and jump in the same cycle: branch wins
        branch_taken = 1'b1; branch_target = 32'h0000_0202;
        jump = 1'b1; jump_target = 32'h0000_0300;
        step();
        chk("redir_addr", bus.imem_addr, 32'h0000_0200);
        chk("redir_valid", {31'd0, valid_out}, 32'd0);
        branch_taken = 1'b0; jump = 1'b0;
        step();

        // Redirect while stalled in HELD
        stall = 1'b1;
        step();
        step();
        jump = 1'b1; jump_target = 32'h0000_0404;
        step();
        chk("held_redir_addr", bus.imem_addr, 32'h0000_0404);
        chk("held_redir_req", {31'd0, bus.imem_req}, 32'd1);
        jump = 1'b0; stall = 1'b0;
        step();

        // Memory not ready for two cycles
        ready = 1'b0;
        step();
        step();
        chk("notready_valid", {31'd0, valid_out}, 32'd0);
        ready = 1'b1;
        step();

        // Reset while HELD drops the captured word
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        compare_all();
        step();
        chk("rst_held_npc", next_pc_out, 32'h0);
        chk("rst_held_addr", bus.imem_addr, 32'h0);
        rst_n = 1'b1; stall = 1'b0;

        // Second instance: wrap-around from RESET_PC 0xFFFF_FFFC
        #1;
        chk("wrap_addr_rst", bus2.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_npc", next_pc_out2, 32'h0000_0000);
        chk("wrap_addr", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_ins", instruccion_out2, 32'hFFFF_FFFC ^ 32'hA5A5_0000);
        chk("wrap_valid", {31'd0, valid_out2}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 49) != 0);
            ready         = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            salt          = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
